// File: rtl/age_select_unit_if.sv
// Output handshake bundle of the age select unit toward dispatch.
// Ports: out_valid/out_idx/out_data (master drives), out_ready (slave drives).
interface age_select_unit_if #(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 5
);
    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/age_select_unit.sv
// Oldest-ready selector: age matrix ordered by allocation, one output stage.
// Ports: clk, resetn, flush, alloc_en/alloc_idx, req_valid/req_data in;
//        grant_oh out; issue = output stage handshake (valid/idx/data/ready).
module age_select_unit #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int DATA_W  = 5
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic                      alloc_en,
    input  logic [IDX_W-1:0]          alloc_idx,
    input  logic [ENTRIES-1:0]        req_valid,
    input  logic [ENTRIES*DATA_W-1:0] req_data,
    output logic [ENTRIES-1:0]        grant_oh,
    age_select_unit_if.master         issue
);

    // older[i][j] = 1 means slot i is older than slot j.
    logic [ENTRIES-1:0] older [ENTRIES];

    logic               alloc_hit;
    logic [ENTRIES-1:0] sel_oh;
    logic [IDX_W-1:0]   sel_idx;
    logic [DATA_W-1:0]  sel_data;
    logic               load;

    logic               v_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  data_q;

    // Out-of-range indices only exist when ENTRIES is not a power of two.
    if (ENTRIES == (1 << IDX_W)) begin : g_full
        assign alloc_hit = alloc_en;
    end else begin : g_part
        assign alloc_hit = alloc_en && (alloc_idx < IDX_W'(ENTRIES));
    end

    // New slot becomes youngest: its row clears, its column sets.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            older <= '{default: '0};
        end else if (alloc_hit) begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    if (i != j) begin
                        if (IDX_W'(i) == alloc_idx) begin
                            older[i][j] <= 1'b0;
                        end else if (IDX_W'(j) == alloc_idx) begin
                            older[i][j] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Pairs with no recorded order fall back to lower index first,
    // so the relation is total and at most one slot survives.
    always_comb begin
        logic blocked;
        sel_oh  = '0;
        blocked = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < ENTRIES; j++) begin
                if (j != i && req_valid[j] &&
                    (older[j][i] || (!older[i][j] && j < i))) begin
                    blocked = 1'b1;
                end
            end
            sel_oh[i] = req_valid[i] && !blocked;
        end
    end

    // sel_oh is one-hot or zero, so OR-reduction encodes and muxes.
    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (sel_oh[i]) begin
                sel_idx  = sel_idx | IDX_W'(i);
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign load     = (!v_q || issue.out_ready) && !flush;
    assign grant_oh = (load && resetn) ? sel_oh : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q    <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
        end else if (flush) begin
            v_q <= 1'b0;
        end else if (load) begin
            v_q <= |sel_oh;
            if (|sel_oh) begin
                idx_q  <= sel_idx;
                data_q <= sel_data;
            end
        end
    end

    assign issue.out_valid = v_q;
    assign issue.out_idx   = idx_q;
    assign issue.out_data  = data_q;

endmodule

// File: tb/tb_age_select_unit.sv
// Randomised + directed bench for age_select_unit.
// Reference orders slots by last-allocation time stamp, then index.
module tb_age_select_unit;
    localparam int N  = 16;
    localparam int IW = 4;
    localparam int DW = 5;

    logic            clk = 1'b0;
    logic            resetn;
    logic            flush;
    logic            alloc_en;
    logic [IW-1:0]   alloc_idx;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant_oh;

    age_select_unit_if #(.IDX_W(IW), .DATA_W(DW)) bus ();

    age_select_unit #(
        .ENTRIES(N),
        .IDX_W  (IW),
        .DATA_W (DW)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .alloc_en (alloc_en),
        .alloc_idx(alloc_idx),
        .req_valid(req_valid),
        .req_data (req_data),
        .grant_oh (grant_oh),
        .issue    (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: stamp 0 = never allocated (oldest); larger = younger.
    int            stamp [N];
    int            now;
    logic          m_valid;
    logic [IW-1:0] m_idx;
    logic [DW-1:0] m_data;
    logic [N-1:0]  last_grant;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_pick();
        int best = -1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i]) begin
                if (best < 0 || stamp[i] < stamp[best]) best = i;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) stamp[i] = 0;
        now     = 0;
        m_valid = 1'b0;
        m_idx   = '0;
        m_data  = '0;
    endtask

    // Called just after a negedge with inputs driven; returns at next negedge.
    task automatic cycle();
        int           w;
        logic         ld;
        logic [N-1:0] eg;
        #1;
        w  = ref_pick();
        ld = !flush && (!m_valid || bus.out_ready);
        eg = '0;
        if (ld && w >= 0) eg[w] = 1'b1;
        chk("grant_oh", 32'(grant_oh), 32'(eg));
        last_grant = eg;
        if (flush) begin
            m_valid = 1'b0;
        end else if (ld) begin
            m_valid = (w >= 0);
            if (w >= 0) begin
                m_idx  = IW'(w);
                m_data = req_data[w*DW +: DW];
            end
        end
        if (alloc_en) begin
            now++;
            stamp[alloc_idx] = now;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_idx", 32'(bus.out_idx), 32'(m_idx));
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        @(negedge clk);
    endtask

    task automatic run_drop(input int n);
        for (int k = 0; k < n; k++) begin
            cycle();
            req_valid = req_valid & ~last_grant;
        end
    endtask

    // Asynchronous reset asserted mid-cycle with requests pending.
    task automatic reset_check();
        logic [N-1:0] keep;
        keep = req_valid;
        #2;
        resetn    = 1'b0;
        req_valid = '1;
        #1;
        chk("rst_grant", 32'(grant_oh), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_idx", 32'(bus.out_idx), 32'h0);
        chk("rst_data", 32'(bus.out_data), 32'h0);
        model_reset();
        @(negedge clk);
        resetn    = 1'b1;
        req_valid = keep;
    endtask

    initial begin
        resetn        = 1'b0;
        flush         = 1'b0;
        alloc_en      = 1'b0;
        alloc_idx     = '0;
        req_valid     = '0;
        req_data      = '0;
        bus.out_ready = 1'b1;
        last_grant    = '0;
        model_reset();
        @(negedge clk);
        reset_check();
        req_valid = '0;

        // Idle, then first request with no allocations.
        cycle();
        cycle();
        req_valid = 16'h0005;
        cycle();
        req_valid = '0;
        cycle();

        // Tie-break by index.
        req_data[8*DW +: DW]  = 5'h0B;
        req_data[11*DW +: DW] = 5'h13;
        req_valid = 16'h0900;
        cycle();
        req_valid = '0;
        cycle();

        // Allocate 3, 1, 7 then issue in age order.
        alloc_en  = 1'b1;
        alloc_idx = 4'd3;
        cycle();
        alloc_idx = 4'd1;
        cycle();
        alloc_idx = 4'd7;
        cycle();
        alloc_en  = 1'b0;
        req_valid = 16'h008A;
        run_drop(4);

        // Reallocate 3: it becomes younger than 1.
        alloc_en  = 1'b1;
        alloc_idx = 4'd3;
        cycle();
        alloc_en  = 1'b0;
        req_valid = 16'h000A;
        run_drop(3);

        // Stall with changing requests, then release.
        req_valid = 16'h0030;
        cycle();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = N'($urandom) | 16'h0001;
            req_data  = (N * DW)'({$urandom, $urandom, $urandom});
            cycle();
        end
        bus.out_ready = 1'b1;
        req_valid = 16'h0040;
        cycle();

        // Flush while stalled; age order survives.
        bus.out_ready = 1'b0;
        req_valid = 16'h0080;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        req_valid = 16'h008A;
        run_drop(4);

        // Random traffic with flush, alloc, back-pressure and a reset.
        for (int k = 0; k < 400; k++) begin
            if (k == 200) reset_check();
            req_valid     = N'($urandom) & N'($urandom);
            req_data      = (N * DW)'({$urandom, $urandom, $urandom});
            alloc_en      = ($urandom_range(0, 3) == 0);
            alloc_idx     = IW'($urandom);
            flush         = ($urandom_range(0, 9) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/age_select_unit.md
Name: age_select_unit

Overview:
- Parametrised successor of the 2-input ready/address select cell, used by the issue queue to pick one request per cycle.
- Arbitrates across ENTRIES request slots and picks the oldest ready slot. Age is tracked internally by an allocation-ordered age matrix.
- The winner's index and payload go into a single output register stage with a valid/ready handshake toward the execute-port dispatch logic.

Parameters:
- ENTRIES, 16, number of request slots (2..32).
- IDX_W, $clog2(ENTRIES), width of a slot index.
- DATA_W, 5, per-slot payload width (operand/physical address).

Ports:
- clk  input  1  single clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; drops the output stage.
- alloc_en  input  1  a slot is being (re)allocated this cycle.
- alloc_idx  input  IDX_W  slot being allocated; becomes the youngest.
- req_valid  input  ENTRIES  per-slot ready/request bit.
- req_data  input  ENTRIES*DATA_W  flattened payloads; slot i occupies bits [i*DATA_W +: DATA_W].
- grant_oh  output  ENTRIES  one-hot; slot captured into the output stage this cycle (combinational).
- out_valid  output  1  output stage holds a selection.
- out_idx  output  IDX_W  selected slot index.
- out_data  output  DATA_W  selected slot payload.
- out_ready  input  1  consumer accepts the output stage.

Behaviour:
- Age matrix: older[i][j], one flop per ordered pair i != j. Reset clears every bit to 0.
- Allocation: on a clk edge with alloc_en=1 and k=alloc_idx:
  - row k (older[k][*]) is cleared;
  - column k (older[*][k]) is set for every j != k;
  - slot k becomes the youngest relative to all others;
  - the new ordering is visible from the next cycle.
  - alloc_idx >= ENTRIES: ignored.
- Blocking rule: slot j blocks slot i iff req_valid[j] && (older[j][i] || (!older[i][j] && j<i)). This gives a total order, so ties and un-allocated pairs resolve with the lower index winning.
- Selection (combinational): sel_oh[i] = req_valid[i] && no slot blocks i. It is one-hot or zero.
- Load condition: load = !out_valid || out_ready, with flush=0.
- grant_oh = load ? sel_oh : 0. The issue queue must deassert req_valid for the granted slot from the next cycle.
- Output register update at each edge:
  - flush=1: out_valid <= 0; out_idx and out_data hold.
  - else if load: out_valid <= |sel_oh; out_idx <= encode(sel_oh); out_data <= req_data of the selected slot; idx/data hold when sel_oh=0.
  - else: hold all outputs (stall).
- Latency: one cycle from request to out_valid. Throughput is one selection per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_idx and out_data are stable and grant_oh=0.
- Simultaneous alloc and select of the same slot: selection uses the pre-edge matrix. The age update applies at the edge.
- Flush and alloc in the same cycle: both take effect. Flush does not touch the age matrix.
- Reset mid-operation: out_valid=0, out_idx=0, out_data=0, matrix cleared, grant_oh=0 while resetn=0.

Test Plan:
- Reset, then req_valid=16'h0000 -> out_valid stays 0 and grant_oh=0; release with req_valid=16'h0005 -> grant_oh=16'h0001, next cycle out_valid=1, out_idx=0.
- Tie-break with no allocations: req_valid=16'h0900, req_data slot 8=5'h0B, slot 11=5'h13 -> out_idx=8, out_data=5'h0B.
- Age order: allocate slots 3, 1, 7 in consecutive cycles, then req_valid=16'h008A -> issue order 3, 1, 7 on three consecutive cycles, req dropped after each grant.
- Reallocation: after the previous case, reallocate slot 3, then req_valid=16'h000A -> out_idx=1 first, then 3.
- Stall: out_valid=1 with out_ready=0 for 3 cycles while other requests change -> out_idx/out_data constant, grant_oh=0; out_ready=1 -> next selection loads on the following edge.
- Flush while stalled with out_valid=1 -> out_valid=0 next cycle; age order is preserved (the next selection still follows the prior allocation order).
